// File: rtl/pattern_gen_if.sv
// pattern_gen_if: line request / register bundle and pixel stream.
// master issues requests and modes, slave returns pixels.
interface pattern_gen_if;
  logic        SLCT_OUT_REQ;
  logic [1:0]  REG_SELECT;
  logic [1:0]  REG_MODE;
  logic        PG_DVLD;
  logic [15:0] PG_DATA;
  logic        PG_LINE_END;
  logic        PG_FRAME_END;

  modport master (
    output SLCT_OUT_REQ, REG_SELECT, REG_MODE,
    input  PG_DVLD, PG_DATA, PG_LINE_END, PG_FRAME_END
  );

  modport slave (
    input  SLCT_OUT_REQ, REG_SELECT, REG_MODE,
    output PG_DVLD, PG_DATA, PG_LINE_END, PG_FRAME_END
  );
endinterface

// File: rtl/pattern_gen.sv
// pattern_gen: bars / checkerboard / grey-ramp line generator.
// Define PATTERN_GEN_SCROLL_EN for per-frame horizontal scroll.
module pattern_gen #(
  parameter int P_LINE     = 800,
  parameter int P_ROW      = 600,
  parameter int P_BAR_NUM  = 8,
  parameter int P_CHK_SIZE = 100
) (
  input  logic         CLK_40M,
  input  logic         SYS_RST,
  pattern_gen_if.slave pg
);
  localparam int BW  = P_LINE / P_BAR_NUM;
  localparam int HW  = P_ROW / P_BAR_NUM;
  localparam int GW  = P_LINE / 16;
  localparam int CK  = P_CHK_SIZE;
  localparam int XW  = $clog2(P_LINE + 1);
  localparam int YW  = (P_ROW > 1) ? $clog2(P_ROW) : 1;
  localparam int BWW = (BW > 1) ? $clog2(BW) : 1;
  localparam int HWW = (HW > 1) ? $clog2(HW) : 1;
  localparam int GWW = (GW > 1) ? $clog2(GW) : 1;
  localparam int CKW = (CK > 1) ? $clog2(CK) : 1;

  typedef enum logic [1:0] {S_IDLE, S_PEND, S_LINE} state_t;

  state_t         state_q, state_d;
  logic           en, req_ok, step;
  logic           last_x, last_y, wrap_x;
  logic [1:0]     mode_q;
  logic [11:0]    rgb;

  logic [XW-1:0]  xc;
  logic [BWW-1:0] vb_rem, vb_rem_n, st_vb_rem;
  logic [2:0]     vb_idx, vb_idx_n, st_vb_idx;
  logic [CKW-1:0] ck_rem, ck_rem_n, st_ck_rem;
  logic           ck_par, ck_par_n, st_ck_par;
  logic [GWW-1:0] gr_rem, gr_rem_n, st_gr_rem;
  logic [3:0]     gr_idx, gr_idx_n, st_gr_idx;

  logic [YW-1:0]  y;
  logic [HWW-1:0] hb_rem;
  logic [2:0]     hb_idx;
  logic [CKW-1:0] yck_rem;
  logic           yck_par;

  logic           dvld_q, lend_q, fend_q;
  logic [15:0]    data_q;

  assign pg.PG_DVLD      = dvld_q;
  assign pg.PG_DATA      = data_q;
  assign pg.PG_LINE_END  = lend_q;
  assign pg.PG_FRAME_END = fend_q;

  assign en     = pg.REG_SELECT == 2'b10;
  assign req_ok = en && pg.SLCT_OUT_REQ &&
                  state_q == S_IDLE && !dvld_q;
  assign step   = state_q == S_LINE && en;
  assign last_x = xc == XW'(P_LINE - 1);
  assign last_y = y == YW'(P_ROW - 1);

  always_ff @(posedge CLK_40M or posedge SYS_RST) begin
    if (SYS_RST) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (req_ok) state_d = S_PEND;
      S_PEND:  state_d = en ? S_LINE : S_IDLE;
      S_LINE:  if (!en || last_x) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    vb_rem_n = vb_rem + 1'b1;
    vb_idx_n = vb_idx;
    ck_rem_n = ck_rem + 1'b1;
    ck_par_n = ck_par;
    gr_rem_n = gr_rem + 1'b1;
    gr_idx_n = gr_idx;
    if (vb_rem == BWW'(BW - 1)) begin
      vb_rem_n = '0;
      vb_idx_n = vb_idx + 1'b1;
    end
    if (ck_rem == CKW'(CK - 1)) begin
      ck_rem_n = '0;
      ck_par_n = ~ck_par;
    end
    if (gr_rem == GWW'(GW - 1)) begin
      gr_rem_n = '0;
      gr_idx_n = gr_idx + 1'b1;
    end
    // scrolled x passes P_LINE-1: restart every index at column 0
    if (wrap_x) begin
      vb_rem_n = '0;
      vb_idx_n = '0;
      ck_rem_n = '0;
      ck_par_n = 1'b0;
      gr_rem_n = '0;
      gr_idx_n = '0;
    end
  end

`ifdef PATTERN_GEN_SCROLL_EN
  logic [XW-1:0]  xs, off, off_n;
  logic [BWW-1:0] off_vb_rem, off_vb_rem_n;
  logic [2:0]     off_vb_idx, off_vb_idx_n;
  logic [CKW-1:0] off_ck_rem, off_ck_rem_n;
  logic           off_ck_par, off_ck_par_n;
  logic [GWW-1:0] off_gr_rem, off_gr_rem_n;
  logic [3:0]     off_gr_idx, off_gr_idx_n;

  assign wrap_x    = xs == XW'(P_LINE - 1);
  assign st_vb_rem = off_vb_rem;
  assign st_vb_idx = off_vb_idx;
  assign st_ck_rem = off_ck_rem;
  assign st_ck_par = off_ck_par;
  assign st_gr_rem = off_gr_rem;
  assign st_gr_idx = off_gr_idx;

  always_comb begin
    off_n        = off + XW'(4);
    off_vb_rem_n = off_vb_rem + BWW'(4);
    off_vb_idx_n = off_vb_idx;
    off_ck_rem_n = off_ck_rem + CKW'(4);
    off_ck_par_n = off_ck_par;
    off_gr_rem_n = off_gr_rem + GWW'(4);
    off_gr_idx_n = off_gr_idx;
    if (int'(off_vb_rem) + 4 >= BW) begin
      off_vb_rem_n = BWW'(int'(off_vb_rem) + 4 - BW);
      off_vb_idx_n = off_vb_idx + 1'b1;
    end
    if (int'(off_ck_rem) + 4 >= CK) begin
      off_ck_rem_n = CKW'(int'(off_ck_rem) + 4 - CK);
      off_ck_par_n = ~off_ck_par;
    end
    if (int'(off_gr_rem) + 4 >= GW) begin
      off_gr_rem_n = GWW'(int'(off_gr_rem) + 4 - GW);
      off_gr_idx_n = off_gr_idx + 1'b1;
    end
    if (off == XW'(P_LINE - 4)) begin
      off_n        = '0;
      off_vb_rem_n = '0;
      off_vb_idx_n = '0;
      off_ck_rem_n = '0;
      off_ck_par_n = 1'b0;
      off_gr_rem_n = '0;
      off_gr_idx_n = '0;
    end
  end

  always_ff @(posedge CLK_40M or posedge SYS_RST) begin
    if (SYS_RST) begin
      xs         <= '0;
      off        <= '0;
      off_vb_rem <= '0;
      off_vb_idx <= '0;
      off_ck_rem <= '0;
      off_ck_par <= 1'b0;
      off_gr_rem <= '0;
      off_gr_idx <= '0;
    end else begin
      if (state_q == S_PEND) xs <= off;
      else if (step)         xs <= wrap_x ? '0 : xs + 1'b1;
      if (step && last_x && last_y) begin
        off        <= off_n;
        off_vb_rem <= off_vb_rem_n;
        off_vb_idx <= off_vb_idx_n;
        off_ck_rem <= off_ck_rem_n;
        off_ck_par <= off_ck_par_n;
        off_gr_rem <= off_gr_rem_n;
        off_gr_idx <= off_gr_idx_n;
      end
    end
  end
`else
  assign wrap_x    = 1'b0;
  assign st_vb_rem = '0;
  assign st_vb_idx = '0;
  assign st_ck_rem = '0;
  assign st_ck_par = 1'b0;
  assign st_gr_rem = '0;
  assign st_gr_idx = '0;
`endif

  function automatic logic [11:0] bar_rgb(input logic [2:0] i);
    logic [11:0] c;
    case (i)
      3'd0: c = 12'hFFF;
      3'd1: c = 12'h000;
      3'd2: c = 12'hFF0;
      3'd3: c = 12'hF0F;
      3'd4: c = 12'h0FF;
      3'd5: c = 12'hF00;
      3'd6: c = 12'h0F0;
      3'd7: c = 12'h00F;
    endcase
    return c;
  endfunction

  always_comb begin
    rgb = '0;
    unique case (mode_q)
      2'd0: rgb = bar_rgb(vb_idx);
      2'd1: rgb = bar_rgb(hb_idx);
      2'd2: rgb = (ck_par ^ yck_par) ? 12'h000 : 12'hFFF;
      2'd3: rgb = {gr_idx, gr_idx, gr_idx};
    endcase
  end

  always_ff @(posedge CLK_40M or posedge SYS_RST) begin
    if (SYS_RST) begin
      mode_q  <= '0;
      xc      <= '0;
      vb_rem  <= '0;
      vb_idx  <= '0;
      ck_rem  <= '0;
      ck_par  <= 1'b0;
      gr_rem  <= '0;
      gr_idx  <= '0;
      y       <= '0;
      hb_rem  <= '0;
      hb_idx  <= '0;
      yck_rem <= '0;
      yck_par <= 1'b0;
      dvld_q  <= 1'b0;
      data_q  <= '0;
      lend_q  <= 1'b0;
      fend_q  <= 1'b0;
    end else begin
      if (req_ok && y == '0) mode_q <= pg.REG_MODE;
      if (state_q == S_PEND) begin
        xc     <= '0;
        vb_rem <= st_vb_rem;
        vb_idx <= st_vb_idx;
        ck_rem <= st_ck_rem;
        ck_par <= st_ck_par;
        gr_rem <= st_gr_rem;
        gr_idx <= st_gr_idx;
      end else if (step) begin
        xc     <= xc + 1'b1;
        vb_rem <= vb_rem_n;
        vb_idx <= vb_idx_n;
        ck_rem <= ck_rem_n;
        ck_par <= ck_par_n;
        gr_rem <= gr_rem_n;
        gr_idx <= gr_idx_n;
      end
      if (step && last_x) begin
        if (last_y) begin
          y       <= '0;
          hb_rem  <= '0;
          hb_idx  <= '0;
          yck_rem <= '0;
          yck_par <= 1'b0;
        end else begin
          y <= y + 1'b1;
          if (hb_rem == HWW'(HW - 1)) begin
            hb_rem <= '0;
            hb_idx <= hb_idx + 1'b1;
          end else begin
            hb_rem <= hb_rem + 1'b1;
          end
          if (yck_rem == CKW'(CK - 1)) begin
            yck_rem <= '0;
            yck_par <= ~yck_par;
          end else begin
            yck_rem <= yck_rem + 1'b1;
          end
        end
      end
      dvld_q <= step;
      data_q <= step ? {4'h0, rgb} : 16'h0000;
      lend_q <= step && last_x;
      fend_q <= step && last_x && last_y;
    end
  end
endmodule

// File: tb/tb_pattern_gen.sv
// tb_pattern_gen: directed line and frame sequences for pattern_gen.
// Short frames (16 lines, 8-pixel squares) keep whole frames cheap.
module tb_pattern_gen;
  localparam int L = 800;
  localparam int R = 16;
  localparam int B = 8;
  localparam int C = 8;

  typedef struct {
    int          tag;
    int          x;
    logic [15:0] exp;
  } vec_t;

  logic        CLK_40M = 1'b0;
  logic        SYS_RST = 1'b1;
  int          checks  = 0;
  int          errors  = 0;
  int          y_m     = 0;
  int          mode_m  = 0;
  int          off_m   = 0;
  int          nv      = 0;
  logic [15:0] cap [0:L-1];
  vec_t        vecs [0:31];

  pattern_gen_if pgi();

  pattern_gen #(
    .P_LINE(L), .P_ROW(R), .P_BAR_NUM(B), .P_CHK_SIZE(C)
  ) dut (
    .CLK_40M(CLK_40M),
    .SYS_RST(SYS_RST),
    .pg     (pgi)
  );

  always #12 CLK_40M = ~CLK_40M;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic add(input int t, input int x, input logic [15:0] e);
    vecs[nv] = '{t, x, e};
    nv++;
  endtask

  function automatic logic [15:0] tbl(input int i);
    case (i % 8)
      0:       return 16'h0FFF;
      1:       return 16'h0000;
      2:       return 16'h0FF0;
      3:       return 16'h0F0F;
      4:       return 16'h00FF;
      5:       return 16'h0F00;
      6:       return 16'h00F0;
      default: return 16'h000F;
    endcase
  endfunction

  function automatic logic [15:0] model(input int md, input int x,
                                        input int y, input int off);
    int xs;
    int g;
    xs = (x + off) % L;
    g  = xs / (L / 16);
    case (md)
      0:       return tbl(xs / (L / B));
      1:       return tbl(y / (R / B));
      2:       return ((xs / C + y / C) % 2 == 0) ? 16'h0FFF : 16'h0000;
      default: return {4'h0, g[3:0], g[3:0], g[3:0]};
    endcase
  endfunction

  task automatic run_line(input int tag, input int req2_px,
                          input int dis_px, input int rst_px);
    int    cyc, n, first, px, miss, extra, bad_z, exp_n;
    int    lend_n, lend_px, fend_n, fend_px;
    bit    done, fe_exp;
    string t;
    cyc = 0; n = 0; first = -1; miss = 0; extra = 0; bad_z = 0;
    lend_n = 0; lend_px = -1; fend_n = 0; fend_px = -1; done = 1'b0;
    exp_n = (dis_px >= 0) ? dis_px + 1 :
            (rst_px >= 0) ? rst_px + 1 : L;
    fe_exp = (y_m == R - 1) && (exp_n == L);
    t = $sformatf("t%0d_y%0d", tag, y_m);
    if (y_m == 0) mode_m = int'(pgi.REG_MODE);
    pgi.SLCT_OUT_REQ = 1'b1;
    while (!done && cyc < 1000) begin
      @(negedge CLK_40M);
      cyc++;
      pgi.SLCT_OUT_REQ = 1'b0;
      if (pgi.PG_DVLD === 1'b1) begin
        if (first < 0) first = cyc;
        px = n;
        if (n < L) cap[n] = pgi.PG_DATA;
        if (pgi.PG_LINE_END)  begin lend_n++; lend_px = px; end
        if (pgi.PG_FRAME_END) begin fend_n++; fend_px = px; end
        n++;
        if (px == req2_px) pgi.SLCT_OUT_REQ = 1'b1;
        if (px == dis_px)  pgi.REG_SELECT = 2'b00;
        if (px == rst_px) begin
          SYS_RST = 1'b1;
          #1;
          chk({t, "_rst_async"}, int'({pgi.PG_DVLD, pgi.PG_LINE_END,
              pgi.PG_FRAME_END, pgi.PG_DATA}), 0);
          @(negedge CLK_40M);
          @(negedge CLK_40M);
          SYS_RST = 1'b0;
        end
      end else begin
        if (pgi.PG_DATA !== 16'h0 || pgi.PG_LINE_END !== 1'b0 ||
            pgi.PG_FRAME_END !== 1'b0) bad_z++;
        if (n > 0) done = 1'b1;
      end
    end
    if (!done) chk({t, "_timeout"}, 0, 1);
    repeat (4) begin
      @(negedge CLK_40M);
      if (pgi.PG_DVLD !== 1'b0) extra++;
    end
    chk({t, "_latency"}, first, 3);
    chk({t, "_nvalid"}, n, exp_n);
    chk({t, "_lend_n"}, lend_n, (exp_n == L) ? 1 : 0);
    chk({t, "_lend_px"}, lend_px, (exp_n == L) ? L - 1 : -1);
    chk({t, "_fend_n"}, fend_n, fe_exp ? 1 : 0);
    chk({t, "_fend_px"}, fend_px, fe_exp ? L - 1 : -1);
    chk({t, "_idle_zero"}, bad_z, 0);
    chk({t, "_no_extra"}, extra, 0);
    for (int i = 0; i < exp_n && i < n; i++)
      if (cap[i] !== model(mode_m, i, y_m, off_m)) miss++;
    chk({t, "_pixels"}, miss, 0);
    for (int k = 0; k < nv; k++)
      if (vecs[k].tag == tag)
        chk($sformatf("%s_x%0d", t, vecs[k].x),
            int'(cap[vecs[k].x]), int'(vecs[k].exp));
    if (rst_px >= 0) begin
      y_m = 0; mode_m = 0; off_m = 0;
    end else if (dis_px < 0) begin
      if (y_m == R - 1) begin
        y_m = 0;
`ifdef PATTERN_GEN_SCROLL_EN
        off_m = (off_m + 4) % L;
`endif
      end else begin
        y_m++;
      end
    end
  endtask

  initial begin
    int cnt;
    add(1, 0, 16'h0FFF);   add(1, 99, 16'h0FFF);
    add(1, 100, 16'h0000); add(1, 199, 16'h0000);
    add(1, 350, 16'h0F0F); add(1, 700, 16'h000F);
    add(1, 799, 16'h000F);
    add(2, 0, 16'h0FFF);   add(2, 150, 16'h0000);
    add(3, 0, 16'h0FFF);   add(3, 799, 16'h0FFF);
    add(4, 0, 16'h0000);   add(4, 799, 16'h0000);
    add(5, 0, 16'h000F);   add(5, 799, 16'h000F);
    add(6, 0, 16'h0FF0);
`ifdef PATTERN_GEN_SCROLL_EN
    add(7, 0, 16'h0000);   add(7, 92, 16'h0FFF);
    add(8, 0, 16'h0FFF);   add(8, 92, 16'h0000);
`else
    add(7, 0, 16'h0FFF);   add(7, 8, 16'h0000);
    add(8, 0, 16'h0000);   add(8, 8, 16'h0FFF);
`endif
    add(9, 49, 16'h0000);  add(9, 50, 16'h0111);
    add(9, 799, 16'h0FFF);

    pgi.SLCT_OUT_REQ = 1'b0;
    pgi.REG_SELECT   = 2'b10;
    pgi.REG_MODE     = 2'd0;
    repeat (3) @(negedge CLK_40M);
    chk("rst_dvld", int'(pgi.PG_DVLD), 0);
    chk("rst_data", int'(pgi.PG_DATA), 0);
    chk("rst_lend", int'(pgi.PG_LINE_END), 0);
    chk("rst_fend", int'(pgi.PG_FRAME_END), 0);
    SYS_RST = 1'b0;
    repeat (3) @(negedge CLK_40M);
    chk("idle_no_req", int'(pgi.PG_DVLD), 0);

    for (int i = 0; i < R; i++) begin
      if (i == 10) pgi.REG_MODE = 2'd1;
      run_line((i == 0) ? 1 : (i == 10) ? 2 : 0,
               (i == 1) ? 300 : -1, -1, -1);
    end

    for (int i = 0; i < R; i++) begin
      if (i == 5) begin
        run_line(0, -1, 400, -1);
        cnt = 0;
        pgi.SLCT_OUT_REQ = 1'b1;
        @(negedge CLK_40M);
        pgi.SLCT_OUT_REQ = 1'b0;
        repeat (5) begin
          @(negedge CLK_40M);
          if (pgi.PG_DVLD !== 1'b0) cnt++;
        end
        chk("req_while_disabled", cnt, 0);
        pgi.REG_SELECT = 2'b10;
      end
      run_line((i == 0) ? 3 : (i == 2) ? 4 : (i == 15) ? 5 :
               (i == 5) ? 6 : 0, -1, -1, -1);
    end

    pgi.REG_MODE = 2'd2;
    for (int i = 0; i < 9; i++)
      run_line((i == 0) ? 7 : (i == 8) ? 8 : 0, -1, -1, -1);
    run_line(0, -1, -1, 200);
    pgi.REG_MODE = 2'd3;
    run_line(9, -1, -1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
